// File: rtl/kcode10to8_dec.sv
// kcode10to8_dec: 8b/10b receive-side control-symbol (K-code) decoder with
//   running-disparity tracking, code/disparity error flags and comma-based
//   link sync (LOS -> CHK -> SYNC).
// Latency: 1 cycle, all outputs registered. Backpressure: none, accepts a
//   symbol every cycle.
// Ports: clk, rst_n (sync, active-low); sym_in/sym_valid in; err_clr in;
//   data_out, k_out, out_valid, code_err, disp_err, in_sync, rd_out,
//   err_count out.
// Optional feature: define KDEC_ERRCNT_EN for a saturating error counter;
//   otherwise err_count is tied to 0 and err_clr is ignored.
module kcode10to8_dec #(
  parameter int unsigned COMMA_CNT = 3,
  parameter int unsigned ERR_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  sym_in,
  input  logic        sym_valid,
  input  logic        err_clr,
  output logic [7:0]  data_out,
  output logic        k_out,
  output logic        out_valid,
  output logic        code_err,
  output logic        disp_err,
  output logic        in_sync,
  output logic        rd_out,
  output logic [15:0] err_count
);

  localparam logic [1:0] ST_LOS  = 2'd0;
  localparam logic [1:0] ST_CHK  = 2'd1;
  localparam logic [1:0] ST_SYNC = 2'd2;

  localparam logic [3:0] COMMA_N = COMMA_CNT[3:0];
  localparam logic [3:0] ERR_N   = ERR_LIMIT[3:0];

  // RD- column lookup; returns {hit, k_value}. The RD+ column is found by
  // feeding the complemented symbol through the same table.
  function automatic logic [8:0] kdec_neg(input logic [9:0] s);
    logic [8:0] r;
    case (s)
      10'h0F4: r = {1'b1, 8'h1C};
      10'h0F9: r = {1'b1, 8'h3C};
      10'h0F5: r = {1'b1, 8'h5C};
      10'h0F3: r = {1'b1, 8'h7C};
      10'h0F2: r = {1'b1, 8'h9C};
      10'h0FA: r = {1'b1, 8'hBC};
      10'h0F6: r = {1'b1, 8'hDC};
      10'h3A8: r = {1'b1, 8'hF7};
      10'h368: r = {1'b1, 8'hFB};
      10'h2E8: r = {1'b1, 8'hFD};
      10'h1E8: r = {1'b1, 8'hFE};
      default: r = 9'h000;
    endcase
    return r;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [3:0]  good_q, good_d;
  logic [3:0]  bad_q, bad_d;
  logic        rd_q, rd_d;
  logic [7:0]  data_q, data_d;
  logic        k_q, k_d;
  logic        vld_q, vld_d;
  logic        code_q, code_d;
  logic        disp_q, disp_d;
  logic        sync_q, sync_d;
  logic [15:0] cnt_q, cnt_d;

  logic [8:0]  neg_lu, pos_lu;
  logic        hit, disp_e, err, is_comma;
  logic [7:0]  kval;
  logic [3:0]  ones;
  logic        rd_next;

  always_comb begin
    neg_lu   = kdec_neg(sym_in);
    pos_lu   = kdec_neg(~sym_in);
    hit      = neg_lu[8] | pos_lu[8];
    kval     = neg_lu[8] ? neg_lu[7:0] : pos_lu[7:0];
    is_comma = hit && (kval == 8'hBC);
    ones     = 4'($countones(sym_in));
    // Hit in the column opposite to the current disparity; masked in LOS
    // because rd has no meaning before the first comma.
    disp_e   = (rd_q ? neg_lu[8] : pos_lu[8]) && (state_q != ST_LOS);
    err      = ~hit | disp_e;

    rd_next = rd_q;
    if (hit) begin
      if (ones == 4'd6)      rd_next = 1'b1;
      else if (ones == 4'd4) rd_next = 1'b0;
    end

    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    if (sym_valid) begin
      case (state_q)
        ST_LOS: begin
          if (is_comma) begin
            if (COMMA_N == 4'd1) begin
              state_d = ST_SYNC;
              good_d  = 4'd0;
            end else begin
              state_d = ST_CHK;
              good_d  = 4'd1;
            end
          end
        end
        ST_CHK: begin
          if (err) begin
            state_d = ST_LOS;
            good_d  = 4'd0;
          end else if (is_comma) begin
            if (good_q + 4'd1 == COMMA_N) begin
              state_d = ST_SYNC;
              good_d  = 4'd0;
            end else begin
              good_d = good_q + 4'd1;
            end
          end
        end
        ST_SYNC: begin
          if (err) begin
            if (bad_q + 4'd1 == ERR_N) begin
              state_d = ST_LOS;
              bad_d   = 4'd0;
            end else begin
              bad_d = bad_q + 4'd1;
            end
          end else begin
            bad_d = 4'd0;
          end
        end
        default: begin
          state_d = ST_LOS;
          good_d  = 4'd0;
          bad_d   = 4'd0;
        end
      endcase
    end

    vld_d  = sym_valid;
    k_d    = sym_valid & hit;
    data_d = (sym_valid && hit) ? kval : 8'h00;
    code_d = sym_valid & ~hit;
    disp_d = sym_valid & disp_e;
    rd_d   = sym_valid ? rd_next : rd_q;
    sync_d = (state_d == ST_SYNC);

`ifdef KDEC_ERRCNT_EN
    cnt_d = cnt_q;
    if (err_clr)
      cnt_d = 16'h0000;
    else if (sym_valid && err && (cnt_q != 16'hFFFF))
      cnt_d = cnt_q + 16'd1;
`else
    cnt_d = 16'h0000;
`endif
  end

`ifndef KDEC_ERRCNT_EN
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_LOS;
      good_q  <= 4'd0;
      bad_q   <= 4'd0;
      rd_q    <= 1'b0;
      data_q  <= 8'h00;
      k_q     <= 1'b0;
      vld_q   <= 1'b0;
      code_q  <= 1'b0;
      disp_q  <= 1'b0;
      sync_q  <= 1'b0;
      cnt_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      k_q     <= k_d;
      vld_q   <= vld_d;
      code_q  <= code_d;
      disp_q  <= disp_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data_out  = data_q;
  assign k_out     = k_q;
  assign out_valid = vld_q;
  assign code_err  = code_q;
  assign disp_err  = disp_q;
  assign in_sync   = sync_q;
  assign rd_out    = rd_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_kcode10to8_dec.sv
// tb_kcode10to8_dec: directed + randomized bench for kcode10to8_dec against
//   a table-driven reference model of the decoder, disparity and sync rules.
module tb_kcode10to8_dec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  sym_in;
  logic        sym_valid;
  logic        err_clr;
  logic [7:0]  data_out;
  logic        k_out, out_valid, code_err, disp_err, in_sync, rd_out;
  logic [15:0] err_count;

  kcode10to8_dec #(.COMMA_CNT(3), .ERR_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .sym_in(sym_in), .sym_valid(sym_valid),
    .err_clr(err_clr), .data_out(data_out), .k_out(k_out),
    .out_valid(out_valid), .code_err(code_err), .disp_err(disp_err),
    .in_sync(in_sync), .rd_out(rd_out), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // RD- column and K values; RD+ column is the complement.
  logic [9:0] tab [11] = '{10'h0F4, 10'h0F9, 10'h0F5, 10'h0F3, 10'h0F2, 10'h0FA,
                           10'h0F6, 10'h3A8, 10'h368, 10'h2E8, 10'h1E8};
  logic [7:0] kv  [11] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
                           8'hDC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

  // Reference model state: 0 = LOS, 1 = CHK, 2 = SYNC.
  int   m_state, m_good, m_bad, m_cnt;
  bit   m_rd;
  bit   e_vld, e_k, e_code, e_disp;
  logic [7:0] e_data;

  task automatic model(input bit rst, input bit vld, input logic [9:0] s, input bit clr);
    int idx, col, ones;
    bit hit, err, comma;
    if (rst) begin
      m_state = 0; m_good = 0; m_bad = 0; m_cnt = 0; m_rd = 0;
      e_vld = 0; e_k = 0; e_code = 0; e_disp = 0; e_data = 0;
      return;
    end
    e_vld = vld; e_k = 0; e_code = 0; e_disp = 0; e_data = 0;
    if (vld) begin
      idx = -1; col = 0;
      for (int i = 0; i < 11; i++) begin
        if (s == tab[i])  begin idx = i; col = 0; end
        if (s == ~tab[i]) begin idx = i; col = 1; end
      end
      hit    = (idx >= 0);
      e_k    = hit;
      e_data = hit ? kv[idx] : 8'h00;
      e_code = !hit;
      e_disp = hit && (col != int'(m_rd)) && (m_state != 0);
      err    = e_code || e_disp;
      comma  = hit && (kv[idx] == 8'hBC);
      ones   = $countones(s);
      if (hit && ones == 6) m_rd = 1;
      if (hit && ones == 4) m_rd = 0;
      if (m_state == 0) begin
        if (comma) begin m_state = 1; m_good = 1; end
      end else if (m_state == 1) begin
        if (err) begin m_state = 0; m_good = 0; end
        else if (comma) begin
          m_good++;
          if (m_good == 3) begin m_state = 2; m_good = 0; end
        end
      end else begin
        if (err) begin
          m_bad++;
          if (m_bad == 4) begin m_state = 0; m_bad = 0; end
        end else m_bad = 0;
      end
`ifdef KDEC_ERRCNT_EN
      if (!clr && err && m_cnt < 65535) m_cnt++;
`endif
    end
`ifdef KDEC_ERRCNT_EN
    if (clr) m_cnt = 0;
`endif
  endtask

  task automatic cycle(input bit rst, input bit vld, input logic [9:0] s, input bit clr,
                       input string tag);
    @(negedge clk);
    rst_n = !rst; sym_valid = vld; sym_in = s; err_clr = clr;
    @(posedge clk);
    model(rst, vld, s, clr);
    #1;
    chk({tag, ".flags"}, {26'd0, out_valid, k_out, code_err, disp_err, in_sync, rd_out},
        {26'd0, e_vld, e_k, e_code, e_disp, (m_state == 2), m_rd});
    chk({tag, ".data"}, {24'd0, data_out}, {24'd0, e_data});
    chk({tag, ".cnt"},  {16'd0, err_count}, m_cnt);
  endtask

  task automatic sym(input logic [9:0] s, input string tag);
    cycle(0, 1, s, 0, tag);
  endtask

  task automatic idle(input string tag);
    cycle(0, 0, 10'h000, 0, tag);
  endtask

  initial begin
    int r, i;
    logic [9:0] s;
    rst_n = 0; sym_valid = 0; sym_in = 0; err_clr = 0;
    cycle(1, 0, 10'h000, 0, "rst0");
    cycle(1, 1, 10'h0FA, 0, "rst1");
    chk("rst_outvalid", {31'd0, out_valid}, 0);

    // Acquire sync with alternating K28.5.
    sym(10'h0FA, "k285a"); chk("k285a_rd", {31'd0, rd_out}, 1);
    sym(10'h305, "k285b"); chk("k285b_rd", {31'd0, rd_out}, 0);
    sym(10'h0FA, "k285c"); chk("k285c_sync", {31'd0, in_sync}, 1);
    chk("k285c_data", {24'd0, data_out}, 32'hBC);

    // Wrong-column K28.0 while rd = 1.
    sym(10'h0F4, "k280_wrong"); chk("k280_disp", {31'd0, disp_err}, 1);
    chk("k280_data", {24'd0, data_out}, 32'h1C);

    // Clean comma clears bad, then four code errors drop sync.
    sym(10'h305, "clean");
    for (i = 0; i < 5; i++) sym(10'h000, $sformatf("zero%0d", i));
    chk("zero_los", {31'd0, in_sync}, 0);

    // CHK abort on code error, then full reacquire.
    sym(m_rd ? 10'h305 : 10'h0FA, "chk1");
    sym(m_rd ? 10'h305 : 10'h0FA, "chk2");
    sym(10'h3FF, "chk_err");
    for (i = 0; i < 3; i++) sym(m_rd ? 10'h305 : 10'h0FA, $sformatf("reacq%0d", i));
    chk("reacq_sync", {31'd0, in_sync}, 1);

    // Every table entry in its legal column, idles in between.
    for (i = 0; i < 11; i++) begin
      s = m_rd ? ~tab[i] : tab[i];
      sym(s, $sformatf("tab%0d", i));
      idle($sformatf("tab_idle%0d", i));
    end

    // Error counter: five errors, then clear with a sixth.
    for (i = 0; i < 5; i++) sym(10'h000, $sformatf("cnt%0d", i));
    cycle(0, 1, 10'h000, 1, "cnt_clr");
    idle("cnt_after");

    // Reset mid-stream discards the symbol.
    cycle(1, 1, 10'h0FA, 0, "mid_rst");

    // Randomized traffic.
    for (i = 0; i < 3000; i++) begin
      r = $urandom_range(99);
      if (r < 40)      s = m_rd ? 10'h305 : 10'h0FA;
      else if (r < 70) begin
        s = tab[$urandom_range(10)];
        if ($urandom_range(3) != 0) s = m_rd ? ~s : s;
        else if ($urandom_range(1) != 0) s = ~s;
      end else s = 10'($urandom);
      cycle($urandom_range(299) == 0, r < 85, s, $urandom_range(29) == 0,
            $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/kcode10to8_dec.md
# kcode10to8_dec

Receive-side K-code decoder for the 8b/10b control-symbol path. It accepts 10-bit line symbols and decodes the eleven control characters (K28.0–K28.6, K23.7, K27.7, K29.7, K30.7) back to their 8-bit values with a K flag. It tracks running disparity, flags code and disparity errors, and runs a comma-based link-sync state machine. It sits between the deserializer/word aligner and the link-layer control logic.

## Interface
- COMMA_CNT, 3: consecutive clean K28.5 symbols needed to declare sync (1–15).
- ERR_LIMIT, 4: consecutive errored symbols in SYNC that drop sync (1–15).
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; synchronous, active-low.
- sym_in  input  10  line symbol, bit 9 = a … bit 0 = j (abcdei_fghj order).
- sym_valid  input  1  sym_in is valid this cycle.
- err_clr  input  1  clears err_count (used only with KDEC_ERRCNT_EN).
- data_out  output  8  decoded K value (0x1C, 0x3C, 0x5C, 0x7C, 0x9C, 0xBC, 0xDC, 0xF7, 0xFB, 0xFD, 0xFE).
- k_out  output  1  data_out is a valid control character.
- out_valid  output  1  one-cycle strobe; outputs correspond to one input symbol.
- code_err  output  1  symbol is not in the K table (either column).
- disp_err  output  1  symbol is valid but from the wrong disparity column.
- in_sync  output  1  sync FSM is in SYNC.
- rd_out  output  1  current running disparity (0 = RD−, 1 = RD+).
- err_count  output  16  saturating error count.

## Operation
- K table, RD− column, has 6b prefix 001111 for K28.x: K28.0 0100, K28.1 1001, K28.2 0101, K28.3 0011, K28.4 0010, K28.5 1010, K28.6 0110. The RD− column for the x.7 codes is K23.7 111010_1000, K27.7 110110_1000, K29.7 101110_1000, K30.7 011110_1000. The RD+ column is the bitwise complement of each entry.
- Match hit, either column: data_out = K value, k_out = 1.
- Disparity check. rd = 0 expects the RD− column; rd = 1 expects the RD+ column. A hit in the other column sets disp_err = 1. Data is still decoded and k_out = 1.
- Disparity update on a hit (including a disp_err hit), based on the symbol's ones count:
  - 6 ones → rd = 1.
  - 4 ones → rd = 0.
  - 5 ones → rd unchanged.
- Miss: code_err = 1, k_out = 0, data_out = 0x00, rd unchanged.
- Errored symbol: code_err or disp_err.
- Sync FSM (advances only on sym_valid):
  - LOS → CHK on any K28.5 hit. Set good = 1, and set rd from the symbol's ones count regardless of disp_err.
  - CHK: errored symbol → LOS. K28.5 → good+1. Other clean symbol → stay, good unchanged. When good reaches COMMA_CNT → SYNC. If COMMA_CNT = 1, LOS goes directly to SYNC on the first K28.5.
  - SYNC: errored symbol → bad+1; clean symbol → bad = 0. When bad reaches ERR_LIMIT → LOS with bad = 0.
- While in LOS, disp_err is suppressed (forced to 0). code_err is still reported.

## Timing
- All outputs are registered. A symbol sampled on edge N appears on outputs, with out_valid = 1, after edge N (latency 1).
- No sym_valid: out_valid = 0. data_out, k_out and the error flags hold 0.
- in_sync and rd_out reflect the state after the symbol just reported, so they update in the same cycle as its out_valid.
- Back-to-back sym_valid is supported every cycle. There is no backpressure.
- Reset (rst_n = 0 at an edge): data_out = 0, k_out = 0, out_valid = 0, code_err = 0, disp_err = 0, in_sync = 0, rd_out = 0, err_count = 0. FSM goes to LOS and good/bad = 0.
- Reset mid-stream discards the in-flight symbol: no out_valid is generated for a symbol sampled on a reset edge.

## Configuration
- KDEC_ERRCNT_EN defined:
  - err_count increments by 1 on each errored out_valid and saturates at 0xFFFF.
  - err_clr = 1 zeroes it on the next edge.
  - If err_clr and an error coincide, the result is 0 (clear wins).
- KDEC_ERRCNT_EN undefined: err_count is tied to 0 and err_clr is ignored. Port list is unchanged.

## Test plan
- Reset, then three K28.5 RD− / RD+ alternating (0x0FA, 0x305, 0x0FA) → data_out = 0xBC, k_out = 1 each. in_sync rises in the cycle the third one is reported. rd_out sequence 1, 0, 1.
- In SYNC with rd = 1, send K28.0 RD− 0x0F4 → disp_err = 1, k_out = 1, data_out = 0x1C. bad = 1, in_sync stays 1.
- In SYNC, send four 0x000 symbols → code_err = 1, data_out = 0x00 each. in_sync = 0 on the fourth report. A fifth 0x000 leaves in_sync = 0.
- In CHK after two K28.5, send 0x3FF → code_err = 1, FSM returns to LOS. Three further clean K28.5 are needed to reach SYNC.
- Decode every table entry in its legal RD column with correct rd sequencing → all eleven K values, no errors. Idle cycles between symbols produce out_valid = 0.
- With KDEC_ERRCNT_EN: five errors, then err_clr together with a sixth error → err_count = 5, then 0. Without the macro, err_count stays 0 throughout.
